data_ram_arbiter: RTL

Two-requester arbiter that shares one port of the 256×32 byte-enabled controller data RAM between two Avalon-MM masters, e.g. the Nios data master and a DMA/control engine. Sits directly in front of one RAM port: it selects a requester every cycle, drives the RAM port, and returns read data with `readdatavalid` to the requester that issued the read. Optionally runs a zero-fill sweep of the RAM after reset before granting any access.

---
 rtl/data_ram_arbiter_if.sv | 41 ++++
 rtl/data_ram_arbiter.sv | 99 +++++++++
 2 files changed

// File: rtl/data_ram_arbiter_if.sv
// rtl/data_ram_arbiter_if.sv - two Avalon-MM requester ports plus the shared RAM port of data_ram_arbiter
interface data_ram_arbiter_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int BE_WIDTH   = 4
);
  logic [ADDR_WIDTH-1:0] m0_address,    m1_address;
  logic [BE_WIDTH-1:0]   m0_byteenable, m1_byteenable;
  logic                  m0_read,       m1_read;
  logic                  m0_write,      m1_write;
  logic [DATA_WIDTH-1:0] m0_writedata,  m1_writedata;
  logic                  m0_waitrequest,   m1_waitrequest;
  logic [DATA_WIDTH-1:0] m0_readdata,      m1_readdata;
  logic                  m0_readdatavalid, m1_readdatavalid;

  logic [ADDR_WIDTH-1:0] ram_address;
  logic [BE_WIDTH-1:0]   ram_byteenable;
  logic                  ram_chipselect;
  logic                  ram_write;
  logic [DATA_WIDTH-1:0] ram_writedata;
  logic [DATA_WIDTH-1:0] ram_readdata;

  // master: requesters and the RAM itself; slave: the arbiter
  modport master (
    output m0_address, m0_byteenable, m0_read, m0_write, m0_writedata,
    output m1_address, m1_byteenable, m1_read, m1_write, m1_writedata,
    input  m0_waitrequest, m0_readdata, m0_readdatavalid,
    input  m1_waitrequest, m1_readdata, m1_readdatavalid,
    input  ram_address, ram_byteenable, ram_chipselect, ram_write, ram_writedata,
    output ram_readdata
  );

  modport slave (
    input  m0_address, m0_byteenable, m0_read, m0_write, m0_writedata,
    input  m1_address, m1_byteenable, m1_read, m1_write, m1_writedata,
    output m0_waitrequest, m0_readdata, m0_readdatavalid,
    output m1_waitrequest, m1_readdata, m1_readdatavalid,
    output ram_address, ram_byteenable, ram_chipselect, ram_write, ram_writedata,
    input  ram_readdata
  );
endinterface

// File: rtl/data_ram_arbiter.sv
// rtl/data_ram_arbiter.sv - round-robin two-master arbiter for one data RAM port
// Define DATA_RAM_ARB_CLEAR_EN to zero-fill the RAM after every reset before granting access.
module data_ram_arbiter #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int BE_WIDTH   = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  data_ram_arbiter_if.slave  bus,
  output logic               busy
);

  logic                  act0, act1;
  logic                  gnt0, gnt1;
  logic                  arb_en, clearing;
  logic                  last_grant;
  logic [1:0]            rd_pending;
  logic [ADDR_WIDTH-1:0] clr_addr;

  assign act0 = bus.m0_read | bus.m0_write;
  assign act1 = bus.m1_read | bus.m1_write;

`ifdef DATA_RAM_ARB_CLEAR_EN
  typedef enum logic {CLEAR, ARB} state_t;
  state_t state;
  logic   busy_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= CLEAR;
      clr_addr <= '0;
      busy_q   <= 1'b1;
    end else if (state == CLEAR) begin
      clr_addr <= clr_addr + ADDR_WIDTH'(1);
      if (&clr_addr) begin
        state  <= ARB;
        busy_q <= 1'b0;
      end
    end
  end

  assign clearing = (state == CLEAR) & reset_n;
  assign arb_en   = (state == ARB) & reset_n;
  assign busy     = busy_q;
`else
  assign clr_addr = '0;
  assign clearing = 1'b0;
  assign arb_en   = reset_n;
  assign busy     = 1'b0;
`endif

  // last_grant=1 means m1 was served last, so m0 takes the next tie
  assign gnt0 = arb_en & act0 & (~act1 | last_grant);
  assign gnt1 = arb_en & act1 & (~act0 | ~last_grant);

  always_comb begin
    bus.ram_address    = bus.m0_address;
    bus.ram_byteenable = bus.m0_byteenable;
    bus.ram_writedata  = bus.m0_writedata;
    bus.ram_chipselect = gnt0;
    bus.ram_write      = gnt0 & bus.m0_write;
    if (clearing) begin
      bus.ram_address    = clr_addr;
      bus.ram_byteenable = {BE_WIDTH{1'b1}};
      bus.ram_writedata  = {DATA_WIDTH{1'b0}};
      bus.ram_chipselect = 1'b1;
      bus.ram_write      = 1'b1;
    end else if (gnt1) begin
      bus.ram_address    = bus.m1_address;
      bus.ram_byteenable = bus.m1_byteenable;
      bus.ram_writedata  = bus.m1_writedata;
      bus.ram_chipselect = 1'b1;
      bus.ram_write      = bus.m1_write;
    end
  end

  assign bus.m0_waitrequest = ~reset_n | clearing | (act0 & ~gnt0);
  assign bus.m1_waitrequest = ~reset_n | clearing | (act1 & ~gnt1);

  // read+write together is a write, so it never produces a return
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_grant <= 1'b1;
      rd_pending <= 2'b00;
    end else begin
      rd_pending <= {gnt1 & bus.m1_read & ~bus.m1_write,
                     gnt0 & bus.m0_read & ~bus.m0_write};
      if (gnt0 | gnt1)
        last_grant <= gnt1;
    end
  end

  assign bus.m0_readdatavalid = rd_pending[0];
  assign bus.m1_readdatavalid = rd_pending[1];
  assign bus.m0_readdata      = bus.ram_readdata;
  assign bus.m1_readdata      = bus.ram_readdata;

endmodule
